// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline: opcodes, forward
// selects, shadow-stage payload and hazard-unit FSM states.
package cpu_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned FWD_W      = 2;
    localparam int unsigned PERF_W     = 16;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_ADD    = 4'h0;
    localparam opcode_t OP_SUB    = 4'h1;
    localparam opcode_t OP_RED    = 4'h2;
    localparam opcode_t OP_XOR    = 4'h3;
    localparam opcode_t OP_SLL    = 4'h4;
    localparam opcode_t OP_SRA    = 4'h5;
    localparam opcode_t OP_ROR    = 4'h6;
    localparam opcode_t OP_PADDSB = 4'h7;
    localparam opcode_t OP_LW     = 4'h8;
    localparam opcode_t OP_SW     = 4'h9;
    localparam opcode_t OP_LHB    = 4'hA;
    localparam opcode_t OP_LLB    = 4'hB;
    localparam opcode_t OP_B      = 4'hC;
    localparam opcode_t OP_BR     = 4'hD;
    localparam opcode_t OP_PCS    = 4'hE;
    localparam opcode_t OP_HLT    = 4'hF;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    // Destination/source info tracked alongside each pipeline stage
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  memread;
        logic                  is_hlt;
        logic [REG_ADDR_W-1:0] src_a;
        logic [REG_ADDR_W-1:0] src_b;
        logic                  use_a;
        logic                  use_b;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Operand select: a younger EX/MEM producer wins over the WB producer; r0 never forwards
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_dst,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  use_src
    );
        fwd_sel = FWD_REG;
        if (use_src && wb_wr && (wb_dst != '0) && (wb_dst == src)) begin
            fwd_sel = FWD_WB;
        end
        if (use_src && mem_wr && (mem_dst != '0) && (mem_dst == src)) begin
            fwd_sel = FWD_MEM;
        end
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Instruction word -> register usage info; all-zero when the word is not valid.
module hazard_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               valid,
    output shadow_t            info_c
);

    opcode_t               op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;

    assign op = instr[15:12];
    assign rd = instr[11:8];
    assign rs = instr[7:4];
    assign rt = instr[3:0];

    // Opcode-driven source/destination classification
    always_comb begin
        info_c = '0;
        if (valid) begin
            info_c.dst = rd;
            case (op)
                OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: begin
                    info_c.regwrite = 1'b1;
                    info_c.src_a    = rs;
                    info_c.use_a    = 1'b1;
                    info_c.src_b    = rt;
                    info_c.use_b    = 1'b1;
                end
                OP_SLL, OP_SRA, OP_ROR: begin
                    info_c.regwrite = 1'b1;
                    info_c.src_a    = rs;
                    info_c.use_a    = 1'b1;
                end
                OP_LW: begin
                    info_c.regwrite = 1'b1;
                    info_c.memread  = 1'b1;
                    info_c.src_a    = rs;
                    info_c.use_a    = 1'b1;
                end
                OP_SW: begin
                    info_c.src_a = rs;
                    info_c.use_a = 1'b1;
                    info_c.src_b = rd;
                    info_c.use_b = 1'b1;
                end
                OP_LHB, OP_LLB: begin
                    info_c.regwrite = 1'b1;
                    info_c.src_a    = rd;
                    info_c.use_a    = 1'b1;
                end
                OP_BR: begin
                    info_c.src_a = rs;
                    info_c.use_a = 1'b1;
                end
                OP_PCS: begin
                    info_c.regwrite = 1'b1;
                end
                OP_HLT: begin
                    info_c.is_hlt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding / load-use hazard / HLT drain unit for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating load-use stall counter.
module hazard_forward_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_ID,
    input  logic               valid_ID,
    input  logic               flush_ID,
    output logic [FWD_W-1:0]   ForwardA,
    output logic [FWD_W-1:0]   ForwardB,
    output logic               stall_IF_ID,
    output logic               bubble_EX,
    output logic               halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  stall_count
`endif
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    shadow_t          ex_q, mem_q, wb_q;
    shadow_t          id_info_c;
    shadow_t          ex_load_c;
    logic             ex_load_valid_c;
    logic             hazard_c;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_bits;

    hazard_decode u_dec_id (
        .instr  (instr_ID),
        .valid  (valid_ID),
        .info_c (id_info_c)
    );

    // Same instruction, but squashed to a zero bubble whenever EX must take a NOP
    assign ex_load_valid_c = valid_ID & ~bubble_EX;

    hazard_decode u_dec_ex (
        .instr  (instr_ID),
        .valid  (ex_load_valid_c),
        .info_c (ex_load_c)
    );

    // Load in EX whose destination is read by the instruction in ID
    assign hazard_c = ex_q.memread && (ex_q.dst != '0) &&
                      ((id_info_c.use_a && (id_info_c.src_a == ex_q.dst)) ||
                       (id_info_c.use_b && (id_info_c.src_b == ex_q.dst)));

    assign ForwardA = fwd_sel(mem_q.regwrite, mem_q.dst, wb_q.regwrite, wb_q.dst,
                              ex_q.src_a, ex_q.use_a);
    assign ForwardB = fwd_sel(mem_q.regwrite, mem_q.dst, wb_q.regwrite, wb_q.dst,
                              ex_q.src_b, ex_q.use_b);

    // Fields carried for completeness but not consumed by this unit
    assign unused_bits = ^{id_info_c.dst, id_info_c.regwrite, id_info_c.memread,
                           wb_q.memread, wb_q.is_hlt, wb_q.src_a, wb_q.src_b,
                           wb_q.use_a, wb_q.use_b};

    // Next state and stall/bubble/halt controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_IF_ID = 1'b0;
        bubble_EX   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_IF_ID = hazard_c & ~flush_ID;
                bubble_EX   = hazard_c | flush_ID;
                // HLT has no sources so it can only be squashed by a flush
                if (id_info_c.is_hlt && !flush_ID) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                stall_IF_ID = 1'b1;
                bubble_EX   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                stall_IF_ID = 1'b1;
                bubble_EX   = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Shadow pipeline advance and FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_load_c;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating count of load-use stalls taken while running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((state_q == ST_RUN) && hazard_c && !flush_ID &&
                     (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-level reference model plus
// directed literal checks and randomized instruction streams.
// Honours HAZARD_PERF_CNT_EN when the design is built with it.
module tb_hazard_forward_unit;

    localparam int DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_ID = '0;
    logic        valid_ID = 1'b0;
    logic        flush_ID = 1'b0;
    logic [1:0]  ForwardA, ForwardB;
    logic        stall_IF_ID, bubble_EX, halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_ID    (instr_ID),
        .valid_ID    (valid_ID),
        .flush_ID    (flush_ID),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .stall_IF_ID (stall_IF_ID),
        .bubble_EX   (bubble_EX),
        .halted      (halted)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // Reference model: raw instruction words in flight plus validity, HLT age, stall tally
    logic [15:0] m_ex = '0, m_mem = '0, m_wb = '0;
    bit          m_ex_v = 0, m_mem_v = 0, m_wb_v = 0;
    int          m_age = -1;
    int          m_cnt = 0;

    function automatic int opc(input logic [15:0] w);
        return int'(w[15:12]);
    endfunction

    function automatic bit uses_a(input logic [15:0] w);
        int op = opc(w);
        return (op <= 9) || (op == 10) || (op == 11) || (op == 13);
    endfunction

    function automatic logic [3:0] src_a(input logic [15:0] w);
        return (opc(w) == 10 || opc(w) == 11) ? w[11:8] : w[7:4];
    endfunction

    function automatic bit uses_b(input logic [15:0] w);
        int op = opc(w);
        return (op <= 3) || (op == 7) || (op == 9);
    endfunction

    function automatic logic [3:0] src_b(input logic [15:0] w);
        return (opc(w) == 9) ? w[11:8] : w[3:0];
    endfunction

    function automatic bit writes(input logic [15:0] w);
        int op = opc(w);
        return (op <= 8) || (op == 10) || (op == 11) || (op == 14);
    endfunction

    function automatic bit produces(input bit v, input logic [15:0] w, input logic [3:0] r);
        return v && writes(w) && (w[11:8] != 4'd0) && (w[11:8] == r);
    endfunction

    function automatic logic [1:0] exp_fwd(input bit side_b);
        bit         u = side_b ? uses_b(m_ex) : uses_a(m_ex);
        logic [3:0] r = side_b ? src_b(m_ex) : src_a(m_ex);
        if (!m_ex_v || !u) return 2'd0;
        if (produces(m_mem_v, m_mem, r)) return 2'd2;
        if (produces(m_wb_v, m_wb, r)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit exp_hz();
        logic [3:0] d = m_ex[11:8];
        if (!m_ex_v || opc(m_ex) != 8 || d == 4'd0 || !valid_ID) return 1'b0;
        return (uses_a(instr_ID) && src_a(instr_ID) == d) ||
               (uses_b(instr_ID) && src_b(instr_ID) == d);
    endfunction

    function automatic bit draining();
        return m_age >= 0;
    endfunction

    function automatic bit exp_stall();
        return draining() ? 1'b1 : (exp_hz() && !flush_ID);
    endfunction

    function automatic bit exp_bubble();
        return draining() ? 1'b1 : (exp_hz() || flush_ID);
    endfunction

    function automatic bit exp_halted();
        return m_age >= DRAIN_CYCLES;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model advance on the active edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ex_v  <= 0;
            m_mem_v <= 0;
            m_wb_v  <= 0;
            m_age   <= -1;
            m_cnt   <= 0;
        end else begin
            m_ex    <= instr_ID;
            m_ex_v  <= valid_ID && !exp_bubble();
            m_mem   <= m_ex;
            m_mem_v <= m_ex_v;
            m_wb    <= m_mem;
            m_wb_v  <= m_mem_v;
            if (!draining() && valid_ID && !flush_ID && opc(instr_ID) == 15)
                m_age <= 0;
            else if (draining() && m_age < DRAIN_CYCLES)
                m_age <= m_age + 1;
            if (!draining() && exp_hz() && !flush_ID && m_cnt < 65535)
                m_cnt <= m_cnt + 1;
        end
    end

    // Model compare on the opposite edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model ForwardA", 16'(ForwardA), 16'(exp_fwd(1'b0)));
            check("model ForwardB", 16'(ForwardB), 16'(exp_fwd(1'b1)));
            check("model stall_IF_ID", 16'(stall_IF_ID), 16'(exp_stall()));
            check("model bubble_EX", 16'(bubble_EX), 16'(exp_bubble()));
            check("model halted", 16'(halted), 16'(exp_halted()));
`ifdef HAZARD_PERF_CNT_EN
            check("model stall_count", stall_count, 16'(m_cnt));
`endif
        end
    end

    task automatic cyc(input logic [15:0] w, input bit v, input bit f);
        @(posedge clk);
        #1;
        instr_ID = w;
        valid_ID = v;
        flush_ID = f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        valid_ID = 1'b0;
        flush_ID = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [15:0] ADD_1_2_3 = 16'h0123;
    localparam logic [15:0] ADD_4_1_5 = 16'h0415;
    localparam logic [15:0] SUB_6_1_1 = 16'h1611;
    localparam logic [15:0] LLB_1     = 16'hB105;
    localparam logic [15:0] LW_2_3    = 16'h8230;
    localparam logic [15:0] SW_2_4    = 16'h9242;
    localparam logic [15:0] LW_0_3    = 16'h8030;
    localparam logic [15:0] SW_0_4    = 16'h9042;
    localparam logic [15:0] HLT       = 16'hF000;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset ForwardA", 16'(ForwardA), 16'd0);
        check("reset ForwardB", 16'(ForwardB), 16'd0);
        check("reset stall", 16'(stall_IF_ID), 16'd0);
        check("reset bubble", 16'(bubble_EX), 16'd0);
        check("reset halted", 16'(halted), 16'd0);

        // Back-to-back dependency: producer in MEM
        cyc(ADD_1_2_3, 1, 0);
        cyc(ADD_4_1_5, 1, 0);
        cyc(16'h0, 0, 0);
        check("adjacent ForwardA", 16'(ForwardA), 16'd2);
        check("adjacent ForwardB", 16'(ForwardB), 16'd0);

        // One NOP apart: producer in WB
        cyc(ADD_1_2_3, 1, 0);
        cyc(16'h0, 0, 0);
        cyc(ADD_4_1_5, 1, 0);
        cyc(16'h0, 0, 0);
        check("gap1 ForwardA", 16'(ForwardA), 16'd1);

        // Both MEM and WB write r1: MEM wins on both operands
        cyc(LLB_1, 1, 0);
        cyc(ADD_1_2_3, 1, 0);
        cyc(SUB_6_1_1, 1, 0);
        cyc(16'h0, 0, 0);
        check("prio ForwardA", 16'(ForwardA), 16'd2);
        check("prio ForwardB", 16'(ForwardB), 16'd2);

        // Load-use on store data: one stall cycle, store reaches EX when the load is in WB
        cyc(LW_2_3, 1, 0);
        cyc(SW_2_4, 1, 0);
        check("lu stall", 16'(stall_IF_ID), 16'd1);
        check("lu bubble", 16'(bubble_EX), 16'd1);
        cyc(SW_2_4, 1, 0);
        check("lu released stall", 16'(stall_IF_ID), 16'd0);
        check("lu bubble in EX ForwardB", 16'(ForwardB), 16'd0);
        cyc(16'h0, 0, 0);
        check("lu store ForwardB", 16'(ForwardB), 16'd1);
        check("lu store ForwardA", 16'(ForwardA), 16'd0);

        // Load into r0 never stalls
        cyc(LW_0_3, 1, 0);
        cyc(SW_0_4, 1, 0);
        check("r0 stall", 16'(stall_IF_ID), 16'd0);
        check("r0 bubble", 16'(bubble_EX), 16'd0);

        // Flush in the hazard cycle: bubble without stall
        cyc(LW_2_3, 1, 0);
        cyc(SW_2_4, 1, 1);
        check("flush bubble", 16'(bubble_EX), 16'd1);
        check("flush stall", 16'(stall_IF_ID), 16'd0);

        // Flushed HLT never drains
        cyc(HLT, 1, 1);
        cyc(16'h0, 0, 0);
        check("flushed hlt stall", 16'(stall_IF_ID), 16'd0);
        cyc(16'h0, 0, 0);
        check("flushed hlt halted", 16'(halted), 16'd0);

        // Real HLT: three drain cycles, then sticky halted
        cyc(HLT, 1, 0);
        check("hlt decode stall", 16'(stall_IF_ID), 16'd0);
        for (int k = 1; k <= DRAIN_CYCLES; k++) begin
            cyc(ADD_1_2_3, 1, 0);
            check("drain stall", 16'(stall_IF_ID), 16'd1);
            check("drain bubble", 16'(bubble_EX), 16'd1);
            check("drain halted", 16'(halted), 16'd0);
        end
        cyc(16'h0, 0, 0);
        check("halted set", 16'(halted), 16'd1);
        check("halted stall", 16'(stall_IF_ID), 16'd1);
        cyc(16'h0, 0, 0);
        check("halted held", 16'(halted), 16'd1);
        do_reset();
        check("post-halt reset halted", 16'(halted), 16'd0);
        check("post-halt reset stall", 16'(stall_IF_ID), 16'd0);

`ifdef HAZARD_PERF_CNT_EN
        for (int k = 0; k < 3; k++) begin
            cyc(LW_2_3, 1, 0);
            cyc(SW_2_4, 1, 0);
            cyc(SW_2_4, 1, 0);
        end
        cyc(16'h0, 0, 0);
        check("perf three stalls", stall_count, 16'd3);
        do_reset();
        check("perf reset", stall_count, 16'd0);
`endif

        // Randomized streams over a small register set to provoke dependencies
        for (int i = 0; i < 4000; i++) begin
            logic [3:0]  op;
            logic [15:0] w;
            @(posedge clk);
            #1;
            if (($urandom_range(0, 299) == 0) ||
                (m_age >= DRAIN_CYCLES + 2 && $urandom_range(0, 3) == 0))
                rst_n = 1'b0;
            else
                rst_n = 1'b1;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h8;
            w = {op, 2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
                 2'b00, 2'($urandom_range(0, 3))};
            instr_ID = w;
            valid_ID = ($urandom_range(0, 7) != 0);
            flush_ID = ($urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
